// File: rtl/tpx3_rx_fifo_arbiter_if.sv
// Bus bundle between the tpx3_rx channel FIFOs, the round-robin arbiter and the readout FIFO.
// Signal names match the system-level port names of the arbiter.
interface tpx3_rx_fifo_arbiter_if #(
    parameter int unsigned N_CH = 4,
    parameter int unsigned CHW  = 2
);
    logic [N_CH-1:0]    CH_ENABLE;
    logic [N_CH-1:0]    CH_FIFO_EMPTY;
    logic [32*N_CH-1:0] CH_FIFO_DATA;
    logic [N_CH-1:0]    CH_FIFO_READ;
    logic               OUT_EMPTY;
    logic [31:0]        OUT_DATA;
    logic [CHW-1:0]     OUT_CH;
    logic               OUT_READ;
    logic               BUSY;

    modport master (
        input  CH_ENABLE, CH_FIFO_EMPTY, CH_FIFO_DATA, OUT_READ,
        output CH_FIFO_READ, OUT_EMPTY, OUT_DATA, OUT_CH, BUSY
    );

    modport slave (
        output CH_ENABLE, CH_FIFO_EMPTY, CH_FIFO_DATA, OUT_READ,
        input  CH_FIFO_READ, OUT_EMPTY, OUT_DATA, OUT_CH, BUSY
    );
endinterface

// File: rtl/tpx3_rx_fifo_arbiter.sv
// Round-robin merge of N tpx3_rx FWFT channel FIFOs into one FWFT output stream,
// one channel per grant, bursts bounded by MAX_BURST, with downstream backpressure.
module tpx3_rx_fifo_arbiter #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned CHW       = 2
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST,
    tpx3_rx_fifo_arbiter_if.master bus
);
    localparam int unsigned DW   = 32;
    localparam int unsigned CNTW = $clog2(MAX_BURST) + 1;

    typedef enum logic {ARB, XFER} state_e;

    state_e          state_q;
    logic [CHW-1:0]  grant_q;
    logic [CHW-1:0]  rr_ptr_q;
    logic [CNTW-1:0] burst_cnt_q;
    logic            out_valid_q;
    logic [DW-1:0]   out_data_q;
    logic [CHW-1:0]  out_ch_q;

    logic [N_CH-1:0] req;
    logic [DW-1:0]   ch_word [N_CH];
    logic [CHW-1:0]  grant_d;
    logic            req_any;
    logic            gnt_ok;
    logic            load;
    logic            burst_last;
    logic [CHW-1:0]  rr_ptr_d;
    logic [N_CH-1:0] rd;
    int unsigned     idx;

    assign req = bus.CH_ENABLE & ~bus.CH_FIFO_EMPTY;

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            ch_word[i] = bus.CH_FIFO_DATA[i*DW +: DW];
        end
    end

    // First requester at or after rr_ptr, wrapping modulo N_CH
    always_comb begin
        grant_d = rr_ptr_q;
        req_any = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            idx = (32'(rr_ptr_q) + k) % N_CH;
            if (req[CHW'(idx)] && !req_any) begin
                grant_d = CHW'(idx);
                req_any = 1'b1;
            end
        end
    end

    assign gnt_ok     = bus.CH_ENABLE[grant_q] & ~bus.CH_FIFO_EMPTY[grant_q];
    assign load       = (state_q == XFER) && gnt_ok && (!out_valid_q || bus.OUT_READ);
    assign burst_last = (burst_cnt_q == CNTW'(MAX_BURST - 1));
    assign rr_ptr_d   = (grant_q == CHW'(N_CH - 1)) ? '0 : CHW'(grant_q + 1'b1);

    always_comb begin
        rd = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            rd[i] = load && (grant_q == CHW'(i));
        end
    end

    assign bus.CH_FIFO_READ = rd;
    assign bus.OUT_EMPTY    = ~out_valid_q;
    assign bus.OUT_DATA     = out_data_q;
    assign bus.OUT_CH       = out_ch_q;
    assign bus.BUSY         = (state_q == XFER);

    // A reset drops any word held in the output register; upstream FIFOs are left as they are
    always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
        if (BUS_RST) begin
            state_q     <= ARB;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            if (load) begin
                out_data_q  <= ch_word[grant_q];
                out_ch_q    <= grant_q;
                out_valid_q <= 1'b1;
                burst_cnt_q <= burst_cnt_q + CNTW'(1);
            end else if (bus.OUT_READ) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                ARB: begin
                    if (req_any) begin
                        grant_q     <= grant_d;
                        burst_cnt_q <= '0;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    // A backpressure stall keeps the grant; only burst end or a dry/disabled channel ends it
                    if ((load && burst_last) || !gnt_ok) begin
                        state_q  <= ARB;
                        rr_ptr_q <= rr_ptr_d;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end
endmodule

// File: doc/tpx3_rx_fifo_arbiter.md
Name: tpx3_rx_fifo_arbiter

Overview:
- Round-robin scheduler that merges the 32-bit first-word-fall-through output FIFOs of N tpx3_rx receiver channels into one FWFT-style output stream.
- The output stream feeds the shared readout FIFO or the SiTCP/USB path.
- Grants one channel at a time, for a bounded burst, and honours a per-channel enable mask and downstream backpressure.
- Sits between the tpx3_rx instances and the system readout FIFO, in the BUS_CLK domain.

Parameters:
- N_CH, 4, number of receiver channels (1..16).
- MAX_BURST, 16, maximum words popped per grant (1..256).
- CHW, 2, channel index width; must equal max(1, clog2(N_CH)).

Ports:
- BUS_CLK  input  1  single clock for all logic; all channel FIFOs are read in this domain.
- BUS_RST  input  1  asynchronous, active-high reset.
- CH_ENABLE  input  N_CH  per-channel enable mask; a disabled channel is never granted.
- CH_FIFO_EMPTY  input  N_CH  per-channel FWFT empty flag; when low, the matching CH_FIFO_DATA slice is valid.
- CH_FIFO_DATA  input  32*N_CH  channel words; channel i occupies bits [32*i+31:32*i].
- CH_FIFO_READ  output  N_CH  per-channel pop strobe, combinational, at most one bit high.
- OUT_EMPTY  output  1  low when OUT_DATA/OUT_CH hold a valid word.
- OUT_DATA  output  32  output word, registered.
- OUT_CH  output  CHW  source channel of OUT_DATA, registered.
- OUT_READ  input  1  downstream pop; ignored while OUT_EMPTY is high.
- BUSY  output  1  high while in state XFER.

Behaviour:
- Reset (async assert, sync release):
  - state=ARB, grant=0, rr_ptr=0, burst_cnt=0, out_valid=0.
  - OUT_DATA=0, OUT_CH=0, OUT_EMPTY=1, BUSY=0, CH_FIFO_READ=0.
- Eligibility: req[i] = CH_ENABLE[i] & ~CH_FIFO_EMPTY[i].
- State ARB:
  - If any req, grant := the first i with req[i], scanning rr_ptr, rr_ptr+1, ... mod N_CH.
  - Same cycle: burst_cnt := 0, next state XFER.
  - No pop in ARB, so each grant costs a one-cycle bubble.
- State XFER:
  - load = CH_ENABLE[grant] & ~CH_FIFO_EMPTY[grant] & (~out_valid | OUT_READ).
  - CH_FIFO_READ[grant] = load.
  - On load: OUT_DATA := channel word, OUT_CH := grant, out_valid := 1, burst_cnt += 1.
  - On OUT_READ without load: out_valid := 0.
- Exit XFER to ARB, setting rr_ptr := (grant+1) mod N_CH, when either:
  - load occurs with burst_cnt == MAX_BURST-1; or
  - the granted channel is empty or disabled (no load possible from the channel side).
- Backpressure stall: channel non-empty and enabled, out_valid=1, OUT_READ=0 → stay in XFER, no pop, burst_cnt unchanged. A stall never ends a grant.
- Throughput: 1 word/cycle within a burst while downstream reads every cycle.
- Simultaneous OUT_READ and load: the register is replaced with no bubble and out_valid stays 1.
- Channel disabled mid-burst: no further pops from it; return to ARB next cycle. The word already in the output register is kept and delivered.
- rr_ptr wrap: N_CH-1 → 0. With N_CH=1, rr_ptr stays 0 and the only effect is the bursts split by MAX_BURST plus the ARB bubble.
- Ordering: words from one channel leave in FIFO order. No word is dropped or duplicated.
- burst_cnt needs clog2(MAX_BURST)+1 bits, which prevents overflow at MAX_BURST=256.
- Reset mid-burst: immediate return to reset values. A word held in the output register is discarded (documented loss). Upstream FIFOs are not touched.
- Data is passed unchanged; the channel identifier is carried only in OUT_CH (tpx3_rx DATA_IDENTIFIER is already in the word).

Test Plan:
- Reset, then ch0 holds 5 words (0xA0..0xA4), OUT_READ=1 constant → ARB bubble, then OUT_DATA A0..A4 on 5 consecutive cycles, OUT_CH=0, back to ARB, BUSY low.
- N_CH=4, MAX_BURST=16, ch0 and ch1 each preloaded with 20 words, OUT_READ=1 → output order ch0×16, ch1×16, ch0×4, ch1×4, with one bubble between grants.
- Backpressure: OUT_READ held low for 10 cycles mid-burst → exactly one word held, CH_FIFO_READ stays 0, no state change; on release, the sequence continues without loss or duplicate.
- CH_ENABLE[1] cleared at the 3rd word of a ch1 burst → at most 3 ch1 words delivered, next grant goes to ch2 (rr_ptr=2), ch1 never granted until re-enabled.
- Wrap: ch3 and ch0 both pending, rr_ptr=3 → ch3 granted first, then ch0; rr_ptr becomes 1.
- BUS_RST pulsed asynchronously mid-burst (between clock edges) → OUT_EMPTY=1, BUSY=0, CH_FIFO_READ=0 immediately; after release, arbitration restarts from ch0.
